// File: rtl/calc_pkg.sv
// Shared definitions for the button/keypad front end: per-button FSM encoding,
// default timing constants and a counter-width helper.
package calc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } btn_state_t;

    localparam int DEF_TICK_DIV       = 100000;
    localparam int DEF_DEBOUNCE_TICKS = 10;
    localparam int DEF_HOLD_TICKS     = 500;
    localparam int DEF_REPEAT_TICKS   = 100;

    // Bits needed to hold 0..limit inclusive.
    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/debounce_tick_gen.sv
// Sample-tick prescaler shared by every button channel: one-cycle tick every
// TICK_DIV clocks (continuous tick when TICK_DIV is 1).
module debounce_tick_gen
    import calc_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count_reg;

    assign tick = (count_reg == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (tick) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + CW'(1);
        end
    end

endmodule

// File: rtl/button_debounce_multi.sv
// N-channel button front end: sync, tick-sampled debounce, press/release pulses,
// long-press hold pulse and auto-repeat, all channels sharing one tick prescaler.
module button_debounce_multi
    import calc_pkg::*;
#(
    parameter int               N_BTN          = 5,
    parameter int               TICK_DIV       = DEF_TICK_DIV,
    parameter int               DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
    parameter int               HOLD_TICKS     = DEF_HOLD_TICKS,
    parameter int               REPEAT_TICKS   = DEF_REPEAT_TICKS,
    parameter int               REPEAT_EN      = 1,
    parameter logic [N_BTN-1:0] INVERT_MASK    = {N_BTN{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_hold,
    output logic [N_BTN-1:0] btn_repeat,
    output logic             any_press
);

    localparam int DW = cnt_width(DEBOUNCE_TICKS);
    localparam int HW = cnt_width(HOLD_TICKS);
    localparam int RW = cnt_width(REPEAT_TICKS);

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_TICKS - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
    localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_TICKS - 1);

    logic tick;

    debounce_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign any_press = |btn_press;

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
        logic          sync1_reg, sync2_reg;
        logic          level_reg, press_reg, release_reg, hold_reg, repeat_reg;
        logic [DW-1:0] deb_cnt_reg;
        logic          pressed, differs, flip, rise, fall;

        btn_state_t    state_reg, state_next;
        logic [HW-1:0] hold_cnt_reg, hold_cnt_next;
        logic [RW-1:0] rep_cnt_reg, rep_cnt_next;
        logic          hold_next, repeat_next;

        assign pressed = sync2_reg ^ INVERT_MASK[gi];
        assign differs = pressed != level_reg;
        assign flip    = tick && differs && (deb_cnt_reg == DEB_LAST);
        assign rise    = flip && !level_reg;
        assign fall    = flip && level_reg;

        // Sync flops reset to the idle pin level so no channel looks pressed.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                sync1_reg   <= INVERT_MASK[gi];
                sync2_reg   <= INVERT_MASK[gi];
                level_reg   <= 1'b0;
                deb_cnt_reg <= '0;
                press_reg   <= 1'b0;
                release_reg <= 1'b0;
            end else begin
                sync1_reg   <= btn_in[gi];
                sync2_reg   <= sync1_reg;
                press_reg   <= rise;
                release_reg <= fall;
                if (tick) begin
                    if (!differs || flip) begin
                        deb_cnt_reg <= '0;
                    end else begin
                        deb_cnt_reg <= deb_cnt_reg + DW'(1);
                    end
                    if (flip) begin
                        level_reg <= ~level_reg;
                    end
                end
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_reg    <= ST_IDLE;
                hold_cnt_reg <= '0;
                rep_cnt_reg  <= '0;
                hold_reg     <= 1'b0;
                repeat_reg   <= 1'b0;
            end else begin
                state_reg    <= state_next;
                hold_cnt_reg <= hold_cnt_next;
                rep_cnt_reg  <= rep_cnt_next;
                hold_reg     <= hold_next;
                repeat_reg   <= repeat_next;
            end
        end

        // Release is checked first so it masks a hold/repeat on the same tick.
        always_comb begin
            state_next    = state_reg;
            hold_cnt_next = hold_cnt_reg;
            rep_cnt_next  = rep_cnt_reg;
            hold_next     = 1'b0;
            repeat_next   = 1'b0;
            if (fall) begin
                state_next = ST_IDLE;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (rise) begin
                            state_next    = ST_PRESSED;
                            hold_cnt_next = '0;
                        end
                    end
                    ST_PRESSED: begin
                        if (tick) begin
                            hold_cnt_next = hold_cnt_reg + HW'(1);
                            if (hold_cnt_reg == HOLD_LAST) begin
                                hold_next    = 1'b1;
                                state_next   = ST_HELD;
                                rep_cnt_next = '0;
                            end
                        end
                    end
                    ST_HELD: begin
                        if (tick) begin
                            if (rep_cnt_reg == REP_LAST) begin
                                repeat_next  = (REPEAT_EN != 0);
                                rep_cnt_next = '0;
                            end else begin
                                rep_cnt_next = rep_cnt_reg + RW'(1);
                            end
                        end
                    end
                    default: state_next = ST_IDLE;
                endcase
            end
        end

        assign btn_level[gi]   = level_reg;
        assign btn_press[gi]   = press_reg;
        assign btn_release[gi] = release_reg;
        assign btn_hold[gi]    = hold_reg;
        assign btn_repeat[gi]  = repeat_reg;
    end

endmodule

// File: tb/tb_button_debounce_multi.sv
// Bench for button_debounce_multi: cycle-by-cycle comparison with a timeline
// model of the debounce/hold/repeat rules plus directed scenario checks.
module tb_button_debounce_multi;

    localparam int         N    = 3;
    localparam int         TD   = 4;
    localparam int         DEB  = 3;
    localparam int         HOLD = 8;
    localparam int         REP  = 4;
    localparam logic [2:0] MASK = 3'b010;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] btn_in;
    logic [N-1:0] btn_level, btn_press, btn_release, btn_hold, btn_repeat;
    logic         any_press;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    button_debounce_multi #(
        .N_BTN          (N),
        .TICK_DIV       (TD),
        .DEBOUNCE_TICKS (DEB),
        .HOLD_TICKS     (HOLD),
        .REPEAT_TICKS   (REP),
        .REPEAT_EN      (1),
        .INVERT_MASK    (MASK)
    ) dut (
        .clk         (clk),
        .reset       (rst_n),
        .btn_in      (btn_in),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_hold    (btn_hold),
        .btn_repeat  (btn_repeat),
        .any_press   (any_press)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: pin seen two edges late; level flips after DEB consecutive
    // disagreeing tick samples; hold/repeat derived from ticks elapsed since press.
    int           m_c;
    bit           m_h0 [N];
    bit           m_h1 [N];
    bit           m_lvl[N];
    int           m_run[N];
    int           m_t  [N];
    bit           m_tk, m_s;
    logic [N-1:0] e_level, e_press, e_release, e_hold, e_repeat;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_c = 0;
            e_level = '0; e_press = '0; e_release = '0; e_hold = '0; e_repeat = '0;
            for (int i = 0; i < N; i++) begin
                m_h0[i] = 0; m_h1[i] = 0; m_lvl[i] = 0; m_run[i] = 0; m_t[i] = 0;
            end
        end else begin
            m_tk = ((m_c % TD) == TD - 1);
            m_c++;
            e_press = '0; e_release = '0; e_hold = '0; e_repeat = '0;
            for (int i = 0; i < N; i++) begin
                m_s     = m_h1[i];
                m_h1[i] = m_h0[i];
                m_h0[i] = btn_in[i] ^ MASK[i];
                if (m_tk) begin
                    if (m_s != m_lvl[i]) begin
                        m_run[i]++;
                        if (m_run[i] == DEB) begin
                            m_run[i] = 0;
                            m_lvl[i] = m_s;
                            if (m_s) begin
                                e_press[i] = 1'b1;
                                m_t[i] = 0;
                            end else begin
                                e_release[i] = 1'b1;
                            end
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                    if (m_lvl[i] && !e_press[i]) begin
                        m_t[i]++;
                        if (m_t[i] == HOLD) e_hold[i] = 1'b1;
                        else if (m_t[i] > HOLD && ((m_t[i] - HOLD) % REP) == 0) e_repeat[i] = 1'b1;
                    end
                end
                e_level[i] = m_lvl[i];
            end
        end
    end

    // Pulse bookkeeping for the directed scenarios.
    int n_press[N], n_rel[N], n_hold[N], n_rep[N];
    int press_cyc[N], rel_cyc[N], hold_cyc[N];
    int n_any, p1_total;
    int rep_q[$];

    task automatic clear_counts();
        for (int i = 0; i < N; i++) begin
            n_press[i] = 0; n_rel[i] = 0; n_hold[i] = 0; n_rep[i] = 0;
            press_cyc[i] = 0; rel_cyc[i] = 0; hold_cyc[i] = 0;
        end
        n_any = 0;
        rep_q.delete();
    endtask

    always @(posedge clk) begin
        #1;
        cyc++;
        check("model", {btn_level, btn_press, btn_release, btn_hold, btn_repeat, any_press},
                       {e_level, e_press, e_release, e_hold, e_repeat, |e_press});
        for (int i = 0; i < N; i++) begin
            if (btn_press[i])   begin n_press[i]++; press_cyc[i] = cyc; end
            if (btn_release[i]) begin n_rel[i]++;   rel_cyc[i]   = cyc; end
            if (btn_hold[i])    begin n_hold[i]++;  hold_cyc[i]  = cyc; end
            if (btn_repeat[i])  n_rep[i]++;
        end
        if (btn_repeat[0]) rep_q.push_back(cyc);
        if (btn_press[1]) p1_total++;
        if (any_press) n_any++;
    end

    task automatic wait_press(input int ch, input int maxc, output int n);
        n = 0;
        for (int k = 1; k <= maxc; k++) begin
            @(posedge clk);
            #1;
            if (btn_press[ch]) begin
                n = k;
                break;
            end
        end
        total++;
        if (n == 0) begin
            bad++;
            $display("FAIL wait_press ch%0d: got no press expected one within %0d clk", ch, maxc);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int got;
        p1_total = 0;
        clear_counts();
        rst_n  = 1'b0;
        btn_in = MASK;
        repeat (3) @(negedge clk);
        check("reset_outputs", {btn_level, btn_press, btn_release, btn_hold, btn_repeat, any_press}, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Clean press
        clear_counts();
        btn_in[0] = 1'b1;
        wait_press(0, 40, n);
        check("press_latency_11_to_14", (n >= 11 && n <= 14), 1);
        @(posedge clk); #1;
        check("press_width", btn_press[0], 0);
        check("level_after_press", btn_level[0], 1);
        @(negedge clk);
        check("clean_press_once", n_press[0], 1);
        check("any_press_once", n_any, 1);
        btn_in[0] = 1'b0;
        repeat (24) @(negedge clk);
        check("clean_release_once", n_rel[0], 1);

        // Bounce: 5-clk toggles, then settle high
        clear_counts();
        for (int k = 0; k < 12; k++) begin
            btn_in[0] = ~btn_in[0];
            repeat (5) @(negedge clk);
        end
        check("bounce_no_press", n_press[0], 0);
        btn_in[0] = 1'b1;
        repeat (30) @(negedge clk);
        check("bounce_one_press", n_press[0], 1);
        check("bounce_no_release", n_rel[0], 0);
        btn_in[0] = 1'b0;
        repeat (24) @(negedge clk);

        // Hold and auto-repeat over 40 ticks of high pin
        clear_counts();
        btn_in[0] = 1'b1;
        repeat (160) @(negedge clk);
        btn_in[0] = 1'b0;
        repeat (30) @(negedge clk);
        check("hr_press_once", n_press[0], 1);
        check("hr_hold_once", n_hold[0], 1);
        check("hr_hold_delay", hold_cyc[0] - press_cyc[0], 32);
        check("hr_repeat_count", rep_q.size(), 7);
        if (rep_q.size() > 0) check("hr_first_repeat_gap", rep_q[0] - hold_cyc[0], 16);
        for (int k = 1; k < rep_q.size(); k++) check("hr_repeat_gap", rep_q[k] - rep_q[k-1], 16);
        check("hr_release_once", n_rel[0], 1);
        check("hr_release_delay", rel_cyc[0] - press_cyc[0], 160);
        if (rep_q.size() > 0) check("hr_no_repeat_after_release", rep_q[rep_q.size()-1] < rel_cyc[0], 1);

        // Inverted channel 1
        check("inv_idle_no_press", p1_total, 0);
        clear_counts();
        btn_in[1] = 1'b0;
        repeat (20) @(negedge clk);
        check("inv_press", n_press[1], 1);
        check("inv_level_pressed", btn_level[1], 1);
        btn_in[1] = 1'b1;
        repeat (20) @(negedge clk);
        check("inv_release", n_rel[1], 1);
        check("inv_level_released", btn_level[1], 0);

        // Reset while channel 0 is held
        clear_counts();
        btn_in[0] = 1'b1;
        got = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (n_hold[0] > 0) begin
                got = 1;
                break;
            end
        end
        check("hold_before_reset", got, 1);
        repeat (2) @(negedge clk);
        check("held_level_before_reset", btn_level[0], 1);
        rst_n = 1'b0;
        #1;
        check("reset_mid_outputs", {btn_level, btn_press, btn_release, btn_hold, btn_repeat, any_press}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_counts();
        wait_press(0, 40, n);
        check("repress_latency", n, 12);
        repeat (40) @(negedge clk);
        check("repress_once", n_press[0], 1);
        check("rehold_once", n_hold[0], 1);
        check("rehold_delay", hold_cyc[0] - press_cyc[0], 32);
        btn_in[0] = 1'b0;
        repeat (30) @(negedge clk);

        // Simultaneous press on 0 and 2, released on the hold tick
        clear_counts();
        btn_in = 3'b111;
        repeat (32) @(negedge clk);
        btn_in = 3'b010;
        repeat (30) @(negedge clk);
        check("sim_press0", n_press[0], 1);
        check("sim_press2", n_press[2], 1);
        check("sim_same_cycle", press_cyc[0] == press_cyc[2], 1);
        check("sim_any_press_width", n_any, 1);
        check("sim_no_hold0", n_hold[0], 0);
        check("sim_no_hold2", n_hold[2], 0);
        check("sim_release0", n_rel[0], 1);
        check("sim_release2", n_rel[2], 1);
        check("sim_release_on_hold_tick", rel_cyc[0] - press_cyc[0], 32);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
